// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: load/store ALU_Control codes,
// FSM state encoding and an access-size decoder.
package mem_pkg;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    // Anything not recognised as a byte/half op is treated as a full word.
    function automatic mem_size_t access_size(input logic [5:0] ctrl);
        mem_size_t sz;
        case (ctrl)
            LB, LBU, SB: sz = SZ_BYTE;
            LH, LHU, SH: sz = SZ_HALF;
            default:     sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: byte enables, store data replication and
// load extraction with sign/zero extension (little-endian).
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [5:0]  alu_ctrl,
    input  logic [1:0]  sel,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    mem_size_t   size;
    logic        sext;
    logic [7:0]  bval;
    logic [15:0] hval;

    assign size = access_size(alu_ctrl);
    assign sext = (alu_ctrl == LB) || (alu_ctrl == LH);
    assign bval = rdata[{sel, 3'b000} +: 8];
    assign hval = sel[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        unique case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << sel;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{sext & bval[7]}}, bval};
            end
            SZ_HALF: begin
                be        = sel[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{sext & hval[15]}}, hval};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory handshake with ack timeout, EXE stall and WB
// output registers. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses (Misalign_OUT).
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_IN,
    input  logic [31:0] Instr1_PC_IN,
    input  logic [31:0] ALU_result1_IN,
    input  logic [4:0]  WriteRegister1_IN,
    input  logic        RegWrite1_IN,
    input  logic [31:0] MemWriteData1_IN,
    input  logic [5:0]  ALU_Control1_IN,
    input  logic        MemRead1_IN,
    input  logic        MemWrite1_IN,
    output logic        STALL_OUT,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr1_PC_OUT,
    output logic [31:0] WriteData1_OUT,
    output logic [4:0]  WriteRegister1_OUT,
    output logic        RegWrite1_OUT,
    output logic        MemFault_OUT
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        Misalign_OUT
`endif
);

    localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

    mem_state_t  state, state_next;
    logic [7:0]  wait_cnt;
    logic        misalign, access, in_wait, timeout;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, load_data;

    mem_lane_align u_align (
        .alu_ctrl   (ALU_Control1_IN),
        .sel        (ALU_result1_IN[1:0]),
        .store_data (MemWriteData1_IN),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        unique case (access_size(ALU_Control1_IN))
            SZ_HALF: misalign = ALU_result1_IN[0];
            SZ_WORD: misalign = |ALU_result1_IN[1:0];
            default: misalign = 1'b0;
        endcase
        misalign = misalign & (MemRead1_IN | MemWrite1_IN) & (state == IDLE);
    end
`else
    assign misalign = 1'b0;
`endif

    assign access  = (MemRead1_IN | MemWrite1_IN) & ~misalign;
    assign in_wait = (state == WAIT);
    // The final WAIT cycle still has req high, so an ack arriving then wins over the fault.
    assign timeout = in_wait & ~dmem_ack & (wait_cnt == LAST_WAIT);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (access) state_next = WAIT;
            WAIT:    if (dmem_ack || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        STALL_OUT  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_be    = '0;
        case (state)
            IDLE: STALL_OUT = access;
            WAIT: begin
                STALL_OUT  = ~dmem_ack & ~timeout;
                dmem_req   = 1'b1;
                dmem_we    = MemWrite1_IN;
                dmem_addr  = {ALU_result1_IN[31:2], 2'b00};
                dmem_wdata = lane_wdata;
                dmem_be    = lane_be;
            end
            default: ;
        endcase
        if (!RESET) STALL_OUT = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)                               wait_cnt <= '0;
        else if (!in_wait || dmem_ack || timeout) wait_cnt <= '0;
        else if (wait_cnt != LAST_WAIT)           wait_cnt <= wait_cnt + 8'd1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Instr1_OUT         <= '0;
            Instr1_PC_OUT      <= '0;
            WriteData1_OUT     <= '0;
            WriteRegister1_OUT <= '0;
            RegWrite1_OUT      <= 1'b0;
            MemFault_OUT       <= 1'b0;
        end else begin
            if (timeout) MemFault_OUT <= 1'b1;
            if (STALL_OUT) begin
                Instr1_OUT         <= '0;
                Instr1_PC_OUT      <= '0;
                WriteData1_OUT     <= '0;
                WriteRegister1_OUT <= '0;
                RegWrite1_OUT      <= 1'b0;
            end else begin
                Instr1_OUT         <= Instr1_IN;
                Instr1_PC_OUT      <= Instr1_PC_IN;
                WriteRegister1_OUT <= WriteRegister1_IN;
                RegWrite1_OUT      <= RegWrite1_IN & ~MemWrite1_IN & ~timeout & ~misalign;
                if (in_wait) WriteData1_OUT <= (dmem_ack & MemRead1_IN) ? load_data : '0;
                else         WriteData1_OUT <= ALU_result1_IN;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) Misalign_OUT <= 1'b0;
        else        Misalign_OUT <= misalign;
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage with an arithmetic reference model
// of lane steering and ack timing. Honours MEM_ALIGN_CHECK_EN when defined.
`timescale 1ns/1ps
module tb_mem_stage;
    import mem_pkg::*;

    localparam int unsigned T = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
    logic [4:0]  WriteRegister1_IN;
    logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
    logic [5:0]  ALU_Control1_IN;
    logic        STALL_OUT, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT;
    logic [4:0]  WriteRegister1_OUT;
    logic        RegWrite1_OUT, MemFault_OUT;
`ifdef MEM_ALIGN_CHECK_EN
    logic        Misalign_OUT;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic        rw;
        bit          chk_wdata;
        bit          mis;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   exp_fault = 1'b0;

    always #5 CLK = ~CLK;

    mem_stage #(.ACK_TIMEOUT(T)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .Instr1_IN          (Instr1_IN),
        .Instr1_PC_IN       (Instr1_PC_IN),
        .ALU_result1_IN     (ALU_result1_IN),
        .WriteRegister1_IN  (WriteRegister1_IN),
        .RegWrite1_IN       (RegWrite1_IN),
        .MemWriteData1_IN   (MemWriteData1_IN),
        .ALU_Control1_IN    (ALU_Control1_IN),
        .MemRead1_IN        (MemRead1_IN),
        .MemWrite1_IN       (MemWrite1_IN),
        .STALL_OUT          (STALL_OUT),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_be            (dmem_be),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .Instr1_OUT         (Instr1_OUT),
        .Instr1_PC_OUT      (Instr1_PC_OUT),
        .WriteData1_OUT     (WriteData1_OUT),
        .WriteRegister1_OUT (WriteRegister1_OUT),
        .RegWrite1_OUT      (RegWrite1_OUT),
        .MemFault_OUT       (MemFault_OUT)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .Misalign_OUT       (Misalign_OUT)
`endif
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: widths in bytes, first lane = address rounded down to the access size.
    function automatic int unsigned op_size(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic int unsigned lane0(input logic [5:0] op, input logic [31:0] addr);
        int unsigned a = addr[1:0];
        int unsigned s = op_size(op);
        return (a / s) * s;
    endfunction

    function automatic logic [3:0] ref_be(input logic [5:0] op, input logic [31:0] addr);
        return 4'(((1 << op_size(op)) - 1) << lane0(op, addr));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] data);
        logic [31:0] r;
        int unsigned s = op_size(op);
        for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = data[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned s = op_size(op);
        longint v;
        v = (longint'(rdata) >> (8 * lane0(op, addr))) & ((longint'(1) << (8 * s)) - 1);
        if ((op == LB || op == LH) && (((v >> (8 * s - 1)) & 1) == 1))
            v = v - (longint'(1) << (8 * s));
        return v[31:0];
    endfunction

    function automatic bit misaligned(input logic [5:0] op, input logic [31:0] addr);
        int unsigned a = addr[1:0];
        return (a % op_size(op)) != 0;
    endfunction

    function automatic logic [255:0] all_outs();
        return {Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT, WriteRegister1_OUT, RegWrite1_OUT,
                MemFault_OUT, STALL_OUT, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata};
    endfunction

    // n = WAIT cycle carrying the ack; n > T means no ack (timeout). idle_ack 2 = random.
    task automatic issue(input logic [5:0] op, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic rw,
                         input logic [4:0] wreg, input int unsigned n,
                         input logic [31:0] rdat, input int idle_ack);
        exp_t e;
        bit acc, mis, ack, tout, fin;
        int unsigned k;
        @(negedge CLK);
        Instr1_IN         = $urandom | 32'h1;
        Instr1_PC_IN      = $urandom;
        ALU_result1_IN    = addr;
        MemWriteData1_IN  = sdata;
        ALU_Control1_IN   = op;
        MemRead1_IN       = rd;
        MemWrite1_IN      = wr;
        RegWrite1_IN      = rw;
        WriteRegister1_IN = wreg;
        dmem_ack          = (idle_ack > 1) ? 1'($urandom_range(0, 1)) : (idle_ack == 1);
        dmem_rdata        = $urandom;
        acc = rd | wr;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = acc && misaligned(op, addr);
        acc = acc && !mis;
`endif
        #1;
        chk("idle_stall", STALL_OUT, acc);
        chk("idle_dmem", {dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata}, '0);
        e.instr     = Instr1_IN;
        e.pc        = Instr1_PC_IN;
        e.wreg      = wreg;
        e.mis       = mis;
        e.rw        = rw && !wr && !mis;
        e.wdata     = addr;
        e.chk_wdata = !mis;
        fin = !acc;
        ack = 1'b0;
        k = 0;
        while (!fin) begin
            @(negedge CLK);
            k++;
            ack  = (k == n);
            tout = !ack && (k == T);
            dmem_ack   = ack;
            dmem_rdata = ack ? rdat : $urandom;
            #1;
            chk("wait_stall", STALL_OUT, !(ack || tout));
            chk("wait_req_we_be_addr", {dmem_req, dmem_we, dmem_be, dmem_addr},
                {1'b1, wr, ref_be(op, addr), addr & 32'hFFFF_FFFC});
            if (wr) chk("wait_wdata", dmem_wdata, ref_wdata(op, sdata));
            fin = ack || tout;
            if (tout) begin
                e.rw = 1'b0;
                exp_fault = 1'b1;
            end
        end
        if (acc) begin
            e.chk_wdata = ack && rd && !wr;
            if (ack) e.wdata = ref_load(op, addr, rdat);
        end
        sb.push_back(e);
    endtask

    task automatic rand_instr();
        logic [5:0] ops [8] = '{LB, LBU, LH, LHU, LW, SB, SH, SW};
        int unsigned r = $urandom_range(0, 11);
        if (r >= 8)
            issue(6'($urandom_range(0, 15)), 1'b0, 1'b0, $urandom, $urandom, 1'($urandom),
                  5'($urandom), 1, $urandom, 2);
        else
            issue(ops[r], r < 5, r >= 5, $urandom, $urandom, 1'($urandom), 5'($urandom),
                  $urandom_range(1, T + 1), $urandom, 2);
    endtask

    task automatic zero_inputs();
        Instr1_IN = '0; Instr1_PC_IN = '0; ALU_result1_IN = '0; MemWriteData1_IN = '0;
        WriteRegister1_IN = '0; RegWrite1_IN = 0; MemRead1_IN = 0; MemWrite1_IN = 0;
        ALU_Control1_IN = '0; dmem_ack = 0; dmem_rdata = '0;
    endtask

    // Monitor: every result leaving the stage is matched against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (RESET === 1'b1) begin
                chk("mem_fault", MemFault_OUT, exp_fault);
                if (Instr1_OUT != 0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", Instr1_OUT, '0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_instr", Instr1_OUT, e.instr);
                        chk("out_pc", Instr1_PC_OUT, e.pc);
                        chk("out_wreg", WriteRegister1_OUT, e.wreg);
                        chk("out_regwrite", RegWrite1_OUT, e.rw);
                        if (e.chk_wdata) chk("out_wdata", WriteData1_OUT, e.wdata);
`ifdef MEM_ALIGN_CHECK_EN
                        chk("out_misalign", Misalign_OUT, e.mis);
`endif
                    end
                end else begin
                    chk("bubble", {Instr1_PC_OUT, WriteData1_OUT, WriteRegister1_OUT,
                                   RegWrite1_OUT}, '0);
                end
            end
        end
    end

    initial begin
        zero_inputs();
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_state", all_outs(), '0);
        RESET = 1'b1;

        issue(6'h02, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 5'd5, 1, 32'h0, 2);
        issue(LB, 1'b1, 1'b0, 32'h0000_1003, 32'h0, 1'b1, 5'd7, 3, 32'h80AA_BBCC, 1);
        issue(SH, 1'b0, 1'b1, 32'h0000_2002, 32'h0000_BEEF, 1'b1, 5'd3, 1, 32'h0, 0);
        issue(LHU, 1'b1, 1'b0, 32'h0000_2002, 32'h0, 1'b1, 5'd4, T, 32'h8123_4567, 0);
        issue(LW, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 1'b1, 5'd9, T + 1, 32'h0, 0);
`ifdef MEM_ALIGN_CHECK_EN
        issue(LW, 1'b1, 1'b0, 32'h0000_1001, 32'h0, 1'b1, 5'd6, 1, 32'h0, 0);
`endif
        repeat (150) rand_instr();

        // Reset while waiting for an ack, then a late ack that must be ignored.
        @(negedge CLK);
        Instr1_IN = 32'hA5A5_0001; ALU_result1_IN = 32'h0000_3000; ALU_Control1_IN = LW;
        MemRead1_IN = 1'b1; MemWrite1_IN = 1'b0; RegWrite1_IN = 1'b1; dmem_ack = 1'b0;
        repeat (2) @(negedge CLK);
        #2;
        RESET = 1'b0;
        exp_fault = 1'b0;
        #1;
        chk("reset_mid_wait", all_outs(), '0);
        dmem_ack = 1'b1;
        @(posedge CLK);
        #1;
        chk("reset_hold", all_outs(), '0);
        @(negedge CLK);
        zero_inputs();
        dmem_ack = 1'b1;
        RESET = 1'b1;
        issue(6'h03, 1'b0, 1'b0, 32'h0000_0123, 32'h0, 1'b1, 5'd2, 1, 32'h0, 1);

        repeat (100) rand_instr();
        @(negedge CLK);
        zero_inputs();
        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", sb.size(), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 64, SHALL set the maximum dmem_ack wait in cycles (range 2..255).
REQ-002 CLK  in  1  clock; all state updates SHALL occur on the rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 Instr1_IN, Instr1_PC_IN  in  32 each  debug instruction and PC from EXE.
REQ-005 ALU_result1_IN  in  32  effective address, or the result for non-memory instructions.
REQ-006 WriteRegister1_IN  in  5; RegWrite1_IN  in  1  destination register and write enable.
REQ-007 MemWriteData1_IN  in  32; ALU_Control1_IN  in  6; MemRead1_IN, MemWrite1_IN  in  1 each.
REQ-008 STALL_OUT  out  1  holds the EXE output registers while high.
REQ-009 dmem_req, dmem_we  out  1; dmem_addr, dmem_wdata  out  32; dmem_be  out  4; dmem_ack  in  1; dmem_rdata  in  32.
REQ-010 Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT  out  32; WriteRegister1_OUT  out  5; RegWrite1_OUT  out  1  (to WB).
REQ-011 MemFault_OUT  out  1  sticky memory-timeout flag.

Function
REQ-012 The FSM SHALL have states IDLE and WAIT.
REQ-013 Access: MemRead1_IN|MemWrite1_IN. In IDLE with an access, STALL_OUT SHALL be 1 combinationally and the next state SHALL be WAIT.
REQ-014 In WAIT, dmem_req SHALL be 1, and dmem_addr SHALL be {ALU_result1_IN[31:2],2'b00}. dmem_we, dmem_be, and the lane-shifted dmem_wdata SHALL all be stable.
REQ-015 In WAIT, STALL_OUT SHALL equal !dmem_ack; on ack the outputs SHALL load and the state SHALL return to IDLE.
REQ-016 Non-access instructions SHALL pass in 1 cycle with WriteData1_OUT=ALU_result1_IN; an access SHALL take 1+N cycles with ack on the Nth WAIT cycle (N>=1).
REQ-017 While STALL_OUT=1, the output registers SHALL load a bubble: all outputs 0.
REQ-018 Byte lanes (little-endian, sel=addr[1:0]): LB/LBU/SB SHALL use lane sel; LH/LHU/SH SHALL use lanes {sel[1],1}/{sel[1],0}; LW/SW SHALL use all lanes.
REQ-019 Loads SHALL right-align the selected lane(s); LB/LH SHALL sign-extend to 32 bits, and LBU/LHU SHALL zero-extend.
REQ-020 Stores SHALL replicate the data byte or halfword across dmem_wdata, and the store output SHALL have RegWrite1_OUT=0.
REQ-021 A WAIT counter SHALL start at 0 on WAIT entry. If it reaches ACK_TIMEOUT without ack, the block SHALL deassert dmem_req, set MemFault_OUT, and emit the instruction with RegWrite1_OUT=0. It SHALL then return to IDLE and deassert STALL_OUT that cycle.
REQ-022 dmem_ack SHALL be ignored in IDLE.
REQ-023 An ack on the timeout cycle SHALL win: the data SHALL be taken and no fault SHALL be raised.
REQ-024 The counter SHALL saturate and SHALL never wrap.

Reset
REQ-025 RESET low SHALL force IDLE, counter 0, MemFault_OUT 0, and all outputs and dmem_* outputs 0, immediately.
REQ-026 Reset mid-WAIT SHALL abandon the access; a late ack after reset SHALL be ignored.

Configuration
REQ-027 With MEM_ALIGN_CHECK_EN defined, a misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) SHALL issue no dmem_req. It SHALL instead produce output Misalign_OUT=1 (1-bit port, 1 cycle) with RegWrite1_OUT=0, in 1 cycle, with no stall.
REQ-028 Without MEM_ALIGN_CHECK_EN, the Misalign_OUT port SHALL be absent and the offending low address bits SHALL be ignored (forced to 0).

Structure
REQ-029 Package mem_pkg SHALL hold the 6-bit ALU_Control codes LB, LBU, LH, LHU, LW, SB, SH, SW and the FSM state enum.
REQ-030 Lane steering (be, wdata replication, load extract/extend) SHALL be the combinational sub-module mem_lane_align.

Verification
REQ-031 ADD result 0x00000010, RegWrite=1, reg 5 -> next edge: WriteData1_OUT=0x10, reg 5, STALL_OUT never 1.
REQ-032 LB at addr 0x1003, rdata=0x80AABBCC, ack after 3 WAIT cycles -> STALL_OUT high 3 cycles, 3 bubbles, then WriteData1_OUT=0xFFFFFF80.
REQ-033 SH at addr 0x2002, data 0x0000BEEF -> dmem_be=4'b1100, dmem_wdata=0xBEEFBEEF, dmem_we=1, RegWrite1_OUT=0.
REQ-034 LW with no ack, ACK_TIMEOUT=4 -> req drops after 4 WAIT cycles, MemFault_OUT=1 until RESET, pipeline resumes.
REQ-035 RESET pulse during WAIT, then ack -> outputs 0, state IDLE, ack ignored.
REQ-036 MEM_ALIGN_CHECK_EN, LW at 0x1001 -> no dmem_req, Misalign_OUT=1 one cycle, RegWrite1_OUT=0.
